// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences 1/2/4-byte IF and MEM requests over a single
// byte-wide RAM port. It assembles and splits little-endian words, pulses a
// one-cycle done on completion, and raises stall_req_o while a requester waits.
// Optional feature macro: ARB_FAIR_EN. When it is defined and both requesters
// are waiting, the grant alternates away from MEM after each MEM grant.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   input  logic              if_flush_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_len_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_dout_o,
   output logic              ram_wr_o,
   input  logic [7:0]        ram_din_i,
   output logic              stall_req_o
);

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t            state, state_nxt;
   logic [2:0]        cnt, len, mem_n;
   logic [ADDR_W-1:0] base, byte_addr;
   logic [31:0]       wdata, asm_q, asm_nxt;
   logic [7:0]        wr_byte;
   logic              can_grant, if_ok, grant_mem, grant_if;
   logic              unused_hi;

   // Address bits above ADDR_W are dropped; addresses wrap modulo 2^ADDR_W.
   assign unused_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

   assign stall_req_o = (mem_req_i & ~mem_done_o) | (if_req_i & ~if_done_o);
   // A pending done forces a bubble cycle before the next grant.
   assign can_grant   = ~if_done_o & ~mem_done_o;
   assign if_ok       = if_req_i & ~if_flush_i;
   assign byte_addr   = base + ADDR_W'(cnt);

`ifdef ARB_FAIR_EN
   logic last_mem;
   assign grant_mem = mem_req_i & ~(if_ok & last_mem);

   // Remember who was granted last so IF waits at most one MEM transaction.
   always_ff @(posedge clk) begin
      if (rst)
         last_mem <= 1'b0;
      else if (state == IDLE && can_grant && (grant_mem || grant_if))
         last_mem <= grant_mem;
   end
`else
   assign grant_mem = mem_req_i;
`endif
   assign grant_if = if_ok & ~grant_mem;

   // Decode the MEM length code; 11 is treated as a word.
   always_comb begin
      case (mem_len_i)
         2'b00:   mem_n = 3'd1;
         2'b01:   mem_n = 3'd2;
         default: mem_n = 3'd4;
      endcase
   end

   // Merge the returning RAM byte into the lane for access cnt-1.
   always_comb begin
      asm_nxt = asm_q;
      case (cnt)
         3'd1:    asm_nxt[7:0]   = ram_din_i;
         3'd2:    asm_nxt[15:8]  = ram_din_i;
         3'd3:    asm_nxt[23:16] = ram_din_i;
         3'd4:    asm_nxt[31:24] = ram_din_i;
         default: asm_nxt = asm_q;
      endcase
   end

   // Select the store byte for the current access.
   always_comb begin
      case (cnt[1:0])
         2'd0:    wr_byte = wdata[7:0];
         2'd1:    wr_byte = wdata[15:8];
         2'd2:    wr_byte = wdata[23:16];
         default: wr_byte = wdata[31:24];
      endcase
   end

   // Next-state and RAM port drive.
   always_comb begin
      state_nxt  = state;
      ram_addr_o = '0;
      ram_dout_o = '0;
      ram_wr_o   = 1'b0;
      case (state)
         IDLE: begin
            if (can_grant) begin
               if (grant_mem)     state_nxt = mem_we_i ? MEM_WR : MEM_RD;
               else if (grant_if) state_nxt = IF_RD;
            end
         end
         IF_RD: begin
            if (cnt < len) ram_addr_o = byte_addr;
            if (if_flush_i || cnt == len) state_nxt = IDLE;
         end
         MEM_RD: begin
            if (cnt < len) ram_addr_o = byte_addr;
            if (cnt == len) state_nxt = IDLE;
         end
         MEM_WR: begin
            ram_wr_o   = 1'b1;
            ram_addr_o = byte_addr;
            ram_dout_o = wr_byte;
            if (cnt == len - 3'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, transaction latches and completion pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         len         <= '0;
         base        <= '0;
         wdata       <= '0;
         asm_q       <= '0;
         if_done_o   <= 1'b0;
         mem_done_o  <= 1'b0;
         if_data_o   <= '0;
         mem_rdata_o <= '0;
      end else begin
         state      <= state_nxt;
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (can_grant && (grant_mem || grant_if)) begin
                  cnt   <= '0;
                  asm_q <= '0;
                  wdata <= mem_wdata_i;
                  base  <= grant_mem ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
                  len   <= grant_mem ? mem_n : 3'd4;
               end
            end
            IF_RD: begin
               if (!if_flush_i) begin
                  asm_q <= asm_nxt;
                  if (cnt == len) begin
                     if_done_o <= 1'b1;
                     if_data_o <= asm_nxt;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            MEM_RD: begin
               asm_q <= asm_nxt;
               if (cnt == len) begin
                  mem_done_o  <= 1'b1;
                  mem_rdata_o <= asm_nxt;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            MEM_WR: begin
               cnt <= cnt + 3'd1;
               if (cnt == len - 3'd1) mem_done_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
